// File: rtl/alu_share_arbiter.sv
// rtl/alu_share_arbiter.sv - round-robin sharing of one ALU among NREQ requesters
module alu_share_arbiter #(
  parameter int NREQ    = 4,
  parameter int IDW     = 2,
  parameter int WIDTH   = 16,
  parameter int OPW     = 5,
  parameter int ALU_LAT = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*OPW-1:0]   req_op,
  input  logic [NREQ*WIDTH-1:0] req_x,
  input  logic [NREQ*WIDTH-1:0] req_y,
  output logic [OPW-1:0]        alu_op,
  output logic [WIDTH-1:0]      alu_x,
  output logic [WIDTH-1:0]      alu_y,
  input  logic [WIDTH-1:0]      alu_z,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [IDW-1:0]        rsp_id,
  output logic [WIDTH-1:0]      rsp_z,
  output logic                  busy
);

  // Counter holds ALU_LAT-1 at most; keep at least one bit for ALU_LAT=1.
  localparam int CNTW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
  // Pointer plus offset can reach 2*NREQ-2, so one extra bit is enough.
  localparam int SW   = IDW + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [IDW-1:0]   r_ptr;
  logic [IDW-1:0]   r_id;
  logic [CNTW-1:0]  r_cnt;
  logic [OPW-1:0]   r_alu_op;
  logic [WIDTH-1:0] r_alu_x;
  logic [WIDTH-1:0] r_alu_y;
  logic             r_rsp_valid;
  logic [IDW-1:0]   r_rsp_id;
  logic [WIDTH-1:0] r_rsp_z;

  logic             w_found;
  logic [IDW-1:0]   w_winner;
  logic [SW-1:0]    w_sum;
  logic [IDW-1:0]   w_idx;
  logic             w_accept;

  // Scan from the pointer upward (mod NREQ); descending loop lets the smallest offset win.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    w_sum    = '0;
    w_idx    = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      w_sum = {1'b0, r_ptr} + SW'(k);
      if (w_sum >= SW'(NREQ)) begin
        w_sum = w_sum - SW'(NREQ);
      end
      w_idx = w_sum[IDW-1:0];
      if (req_valid[w_idx]) begin
        w_found  = 1'b1;
        w_winner = w_idx;
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and grant; grant is gated by rst_n so nothing is accepted during reset.
  always_comb begin
    w_state_nxt = r_state;
    req_ready   = '0;
    w_accept    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_found && rst_n) begin
          req_ready[w_winner] = 1'b1;
          w_accept            = 1'b1;
          w_state_nxt         = S_EXEC;
        end
      end
      S_EXEC: begin
        if (r_cnt == '0) begin
          w_state_nxt = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Operand latch on grant, latency countdown, result capture and response handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr       <= '0;
      r_id        <= '0;
      r_cnt       <= '0;
      r_alu_op    <= '0;
      r_alu_x     <= '0;
      r_alu_y     <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      r_rsp_z     <= '0;
    end else begin
      if (w_accept) begin
        r_alu_op <= req_op[int'(w_winner)*OPW +: OPW];
        r_alu_x  <= req_x[int'(w_winner)*WIDTH +: WIDTH];
        r_alu_y  <= req_y[int'(w_winner)*WIDTH +: WIDTH];
        r_id     <= w_winner;
        r_ptr    <= (w_winner == IDW'(NREQ - 1)) ? '0 : w_winner + 1'b1;
        r_cnt    <= CNTW'(ALU_LAT - 1);
      end
      if (r_state == S_EXEC) begin
        if (r_cnt == '0) begin
          r_rsp_z     <= alu_z;
          r_rsp_id    <= r_id;
          r_rsp_valid <= 1'b1;
        end else begin
          r_cnt <= r_cnt - 1'b1;
        end
      end
      if ((r_state == S_RESP) && rsp_ready) begin
        r_rsp_valid <= 1'b0;
      end
    end
  end

  assign alu_op    = r_alu_op;
  assign alu_x     = r_alu_x;
  assign alu_y     = r_alu_y;
  assign rsp_valid = r_rsp_valid;
  assign rsp_id    = r_rsp_id;
  assign rsp_z     = r_rsp_z;
  assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb/tb_alu_share_arbiter.sv - randomized bench for alu_share_arbiter with timeline reference model
module tb_alu_share_arbiter;
  localparam int NREQ  = 4;
  localparam int IDW   = 2;
  localparam int WIDTH = 16;
  localparam int OPW   = 5;
  localparam int LAT   = 3;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic [NREQ-1:0]       req_valid = '0;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*OPW-1:0]   req_op = '0;
  logic [NREQ*WIDTH-1:0] req_x = '0;
  logic [NREQ*WIDTH-1:0] req_y = '0;
  logic [OPW-1:0]        alu_op;
  logic [WIDTH-1:0]      alu_x;
  logic [WIDTH-1:0]      alu_y;
  logic [WIDTH-1:0]      alu_z;
  logic                  rsp_valid;
  logic                  rsp_ready = 1'b0;
  logic [IDW-1:0]        rsp_id;
  logic [WIDTH-1:0]      rsp_z;
  logic                  busy;

  always #5 clk = ~clk;

  alu_share_arbiter #(.NREQ(NREQ), .IDW(IDW), .WIDTH(WIDTH), .OPW(OPW), .ALU_LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_x(req_x), .req_y(req_y),
    .alu_op(alu_op), .alu_x(alu_x), .alu_y(alu_y), .alu_z(alu_z),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_z(rsp_z), .busy(busy)
  );

  // ALU stub: odd opcodes add, even opcodes xor; result appears LAT-1 edges after inputs change.
  function automatic logic [WIDTH-1:0] alu_f(input logic [OPW-1:0] op,
                                             input logic [WIDTH-1:0] x,
                                             input logic [WIDTH-1:0] y);
    return op[0] ? (x + y) : (x ^ y);
  endfunction

  logic [WIDTH-1:0] stub_s1 = '0;
  logic [WIDTH-1:0] stub_s2 = '0;
  always @(posedge clk) begin
    stub_s1 <= alu_f(alu_op, alu_x, alu_y);
    stub_s2 <= stub_s1;
  end
  assign alu_z = stub_s2;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Requester side
  logic             rv      [NREQ];
  logic [OPW-1:0]   rop     [NREQ];
  logic [WIDTH-1:0] rx      [NREQ];
  logic [WIDTH-1:0] ry      [NREQ];
  bit               granted [NREQ];

  // Reference model: transaction timeline
  int               edge_no = 0;
  int               m_ptr   = 0;
  bit               m_busy  = 0;
  int               m_due   = 0;
  int               m_id    = 0;
  logic [WIDTH-1:0] m_z     = '0;
  logic [OPW-1:0]   m_op    = '0;
  logic [WIDTH-1:0] m_x     = '0;
  logic [WIDTH-1:0] m_y     = '0;

  function automatic int rr_pick(input int ptr, input logic [NREQ-1:0] v);
    int idx;
    for (int k = 0; k < NREQ; k++) begin
      idx = (ptr + k) % NREQ;
      if (v[idx[IDW-1:0]]) return idx;
    end
    return -1;
  endfunction

  task automatic new_data(input int i);
    rop[i] = OPW'($urandom);
    rx[i]  = WIDTH'($urandom);
    ry[i]  = WIDTH'($urandom);
  endtask

  task automatic pack_inputs();
    for (int i = 0; i < NREQ; i++) begin
      req_valid[i]                = rv[i];
      req_op[i*OPW +: OPW]        = rop[i];
      req_x[i*WIDTH +: WIDTH]     = rx[i];
      req_y[i*WIDTH +: WIDTH]     = ry[i];
    end
  endtask

  // One clock: drive at negedge, check, then advance the model across the posedge.
  task automatic cycle(input int p_req, input int p_rdy, input int p_drop);
    int              pick;
    logic [NREQ-1:0] exp_rdy;
    bit              exp_rv;
    @(negedge clk);
    for (int i = 0; i < NREQ; i++) begin
      if (granted[i]) begin
        granted[i] = 0;
        rv[i] = ($urandom_range(99, 0) < p_req);
        new_data(i);
      end else if (!rv[i]) begin
        if ($urandom_range(99, 0) < p_req) begin
          rv[i] = 1'b1;
          new_data(i);
        end
      end else if ($urandom_range(99, 0) < p_drop) begin
        rv[i] = 1'b0;
      end
    end
    pack_inputs();
    rsp_ready = ($urandom_range(99, 0) < p_rdy);
    #1;
    pick    = rr_pick(m_ptr, req_valid);
    exp_rdy = (!m_busy && pick >= 0) ? NREQ'(1 << pick) : '0;
    exp_rv  = m_busy && (edge_no >= m_due);
    chk("req_ready", 32'(req_ready), 32'(exp_rdy));
    chk("busy",      32'(busy),      32'(m_busy));
    chk("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
    if (exp_rv) begin
      chk("rsp_id", 32'(rsp_id), 32'(m_id));
      chk("rsp_z",  32'(rsp_z),  32'(m_z));
    end
    chk("alu_op", 32'(alu_op), 32'(m_op));
    chk("alu_x",  32'(alu_x),  32'(m_x));
    chk("alu_y",  32'(alu_y),  32'(m_y));
    @(posedge clk);
    edge_no++;
    if (!m_busy && pick >= 0) begin
      m_busy = 1;
      m_due  = edge_no + LAT;
      m_id   = pick;
      m_op   = rop[pick];
      m_x    = rx[pick];
      m_y    = ry[pick];
      m_z    = alu_f(m_op, m_x, m_y);
      m_ptr  = (pick + 1) % NREQ;
      granted[pick] = 1;
    end else if (exp_rv && rsp_ready) begin
      m_busy = 0;
    end
  endtask

  task automatic clear_requesters();
    for (int i = 0; i < NREQ; i++) begin
      rv[i] = 1'b0;
      granted[i] = 0;
      rop[i] = '0;
      rx[i] = '0;
      ry[i] = '0;
    end
    pack_inputs();
  endtask

  initial begin
    bit reached;
    clear_requesters();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'(0));
    chk("rst_busy",      32'(busy),      32'(0));
    chk("rst_rsp_valid", 32'(rsp_valid), 32'(0));
    chk("rst_rsp_id",    32'(rsp_id),    32'(0));
    chk("rst_rsp_z",     32'(rsp_z),     32'(0));
    chk("rst_alu_x",     32'(alu_x),     32'(0));
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Idle with no requests, then a single add op from requester 0 (3+4).
    repeat (3) cycle(0, 100, 0);
    rv[0] = 1'b1; rop[0] = 5'b00001; rx[0] = 16'h0003; ry[0] = 16'h0004;
    cycle(0, 100, 0);
    chk("single_z_model", 32'(m_z), 32'(16'h0007));
    repeat (6) cycle(0, 100, 0);

    // All requesters held valid with rsp_ready high: strict rotation.
    repeat (25) cycle(100, 100, 0);
    // Heavy backpressure.
    repeat (80) cycle(50, 10, 3);
    // General random traffic.
    repeat (400) cycle(40, 60, 3);

    // Reset in the middle of an operation.
    reached = 0;
    for (int n = 0; n < 50 && !reached; n++) begin
      cycle(100, 100, 0);
      reached = m_busy && (edge_no < m_due);
    end
    chk("reach_exec", 32'(reached), 32'(1));
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'(0));
    chk("mid_rst_busy",      32'(busy),      32'(0));
    chk("mid_rst_alu_op",    32'(alu_op),    32'(0));
    chk("mid_rst_alu_x",     32'(alu_x),     32'(0));
    chk("mid_rst_alu_y",     32'(alu_y),     32'(0));
    chk("mid_rst_req_ready", 32'(req_ready), 32'(0));
    m_busy = 0; m_ptr = 0; m_op = '0; m_x = '0; m_y = '0;
    @(posedge clk);
    @(negedge clk);
    chk("hold_rst_req_ready", 32'(req_ready), 32'(0));
    clear_requesters();
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) cycle(0, 100, 0);
    repeat (20) cycle(100, 100, 0);
    repeat (300) cycle(35, 50, 5);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
